odo_sbox_chunk_seq: RTL



---
 rtl/odo_sbox_chunk_seq.sv | 81 ++++++++
 1 files changed

// File: rtl/odo_sbox_chunk_seq.sv
// Chunk sequencer around a registered 6-bit sbox: feeds one 6-bit chunk per
// cycle into a single sbox instance and reassembles the substituted word.
module odo_sbox_chunk_seq #(
   parameter int NCHUNK = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6*NCHUNK-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [6*NCHUNK-1:0]   out_data,
   output logic [5:0]            sbox_in,
   input  logic [5:0]            sbox_out
);

   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t                  state, state_nx;
   logic [IW-1:0]           idx;
   logic [NCHUNK-1:0][5:0]  word;
   logic [NCHUNK-1:0][5:0]  res;
   logic                    cap_en;
   logic [IW-1:0]           cap_idx;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)       state_nx = FEED;
         FEED:    if (idx == LAST)    state_nx = DRAIN;
         DRAIN:                       state_nx = DONE;
         DONE:    if (out_ready)      state_nx = IDLE;
         default:                     state_nx = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = res;
   assign sbox_in   = (state == FEED) ? word[idx] : 6'h00;

   // sbox data lags the address by one cycle, so FEED at idx writes chunk idx-1
   // and DRAIN picks up the final chunk.
   assign cap_en  = ((state == FEED) && (idx != '0)) || (state == DRAIN);
   assign cap_idx = (state == DRAIN) ? LAST : idx - IW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         idx  <= '0;
         word <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               word <= in_data;
               idx  <= '0;
            end
            FEED: idx <= (idx == LAST) ? '0 : idx + IW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res <= '0;
      end else begin
         for (int i = 0; i < NCHUNK; i++)
            if (cap_en && (cap_idx == IW'(i))) res[i] <= sbox_out;
      end
   end

endmodule
